// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS32 datapath.
// Strobes are decoded combinationally from the registered state and the held IR fields.
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             to_reg,
  output logic             link,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StFault  = 3'd7
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnJr    = 6'b001000;

  localparam int unsigned     WaitW    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  // Count value seen on the last permitted wait cycle; only meaningful when WAIT_LIMIT != 0.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_LIMIT - 1);

  state_e             state_q, state_d;
  logic               fault_q;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   instr_retired_q;

  logic is_rtype, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_imm, is_legal, wait_hit;

  assign is_rtype = (opcode == OpRtype);
  assign is_j     = (opcode == OpJ);
  assign is_jal   = (opcode == OpJal);
  assign is_beq   = (opcode == OpBeq);
  assign is_bne   = (opcode == OpBne);
  assign is_lw    = (opcode == OpLw);
  assign is_sw    = (opcode == OpSw);
  assign is_imm   = (opcode[5:3] == 3'b001);
  assign is_legal = is_rtype | is_j | is_jal | is_beq | is_bne | is_lw | is_sw | is_imm;
  assign wait_hit = (WAIT_LIMIT != 0) && (wait_cnt_q == WaitLast);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    to_reg       = 1'b0;
    link         = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;

    if (reset) begin
      state_d = StFetch;
    end else begin
      case (state_q)
        StFetch: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = StDecode;
          end else if (wait_hit) begin
            state_d = StFault;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
        StDecode: state_d = is_legal ? StExec : StFault;
        StExec: begin
          if (is_j || is_jal) begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            reg_write = is_jal;
            link      = is_jal;
            state_d   = StFetch;
          end else if (is_rtype && (funct == FnJr)) begin
            pc_write = 1'b1;
            pc_src   = 2'b11;
            state_d  = StFetch;
          end else if (is_beq || is_bne) begin
            pc_write = 1'b1;
            // Branch taken when the equality result matches the branch sense.
            pc_src   = ((zero == is_beq)) ? 2'b01 : 2'b00;
            state_d  = StFetch;
          end else if (is_lw || is_sw) begin
            state_d = StMem;
          end else begin
            state_d = StWb;
          end
        end
        StMem: begin
          mem_addr_sel = 1'b1;
          mem_read     = is_lw;
          mem_write    = ~is_lw;
          if (mem_ready) begin
            if (is_lw) begin
              state_d = StWb;
            end else begin
              pc_write = 1'b1;
              state_d  = StFetch;
            end
          end else if (wait_hit) begin
            state_d = StFault;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
        StWb: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          to_reg    = is_lw;
          reg_dst   = is_rtype;
          state_d   = StFetch;
        end
        StFault: state_d = StFault;
        default: state_d = StFault;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StFetch;
      fault_q         <= 1'b0;
      wait_cnt_q      <= '0;
      instr_retired_q <= '0;
    end else begin
      state_q    <= state_d;
      fault_q    <= (state_d == StFault);
      wait_cnt_q <= wait_cnt_d;
      if (pc_write) begin
        instr_retired_q <= instr_retired_q + CNT_W'(1);
      end
    end
  end

  assign state         = state_q;
  assign fault         = fault_q;
  assign instr_retired = instr_retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle and
// checks state plus the packed strobe vector against hand-derived values.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        mem_read, mem_write, mem_addr_sel, ir_write, reg_write, reg_dst, to_reg, link;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic        fault;
  logic [31:0] instr_retired;

  int checks = 0;
  int errors = 0;

  // {mem_read, mem_write, mem_addr_sel, ir_write, reg_write, reg_dst, to_reg, link, pc_write, pc_src}
  logic [10:0] strb;
  assign strb = {mem_read, mem_write, mem_addr_sel, ir_write, reg_write, reg_dst, to_reg, link,
                 pc_write, pc_src};

  localparam logic [10:0] SNone      = 11'b00000000000;
  localparam logic [10:0] SFetch     = 11'b10010000000;
  localparam logic [10:0] SWait      = 11'b10000000000;
  localparam logic [10:0] SWbR       = 11'b00001100100;
  localparam logic [10:0] SWbLw      = 11'b00001010100;
  localparam logic [10:0] SMemLw     = 11'b10100000000;
  localparam logic [10:0] SMemSw     = 11'b01100000000;
  localparam logic [10:0] SMemSwDone = 11'b01100000100;
  localparam logic [10:0] SBrTaken   = 11'b00000000101;
  localparam logic [10:0] SBrNot     = 11'b00000000100;
  localparam logic [10:0] SJal       = 11'b00001001110;
  localparam logic [10:0] SJr        = 11'b00000000111;

  multicycle_controller #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .to_reg       (to_reg),
    .link         (link),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .state        (state),
    .fault        (fault),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's state and strobes, then advance one clock.
  task automatic step(input string tag, input logic [2:0] exp_state, input logic [10:0] exp_strb);
    #1;
    chk({tag, "_state"}, 32'(state), 32'(exp_state));
    chk({tag, "_strb"}, 32'(strb), 32'(exp_strb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step("rst_hold", 3'd0, SNone);
    reset = 1'b0;
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retired", instr_retired, 32'd0);

    // ADD
    opcode = 6'b000000; funct = 6'b100000;
    step("add_f", 3'd0, SFetch);
    step("add_d", 3'd1, SNone);
    step("add_e", 3'd2, SNone);
    step("add_w", 3'd4, SWbR);
    chk("add_ret", instr_retired, 32'd1);

    // LW with two MEM wait cycles
    opcode = 6'b100011;
    step("lw_f", 3'd0, SFetch);
    step("lw_d", 3'd1, SNone);
    step("lw_e", 3'd2, SNone);
    mem_ready = 1'b0;
    step("lw_m0", 3'd3, SMemLw);
    step("lw_m1", 3'd3, SMemLw);
    mem_ready = 1'b1;
    step("lw_m2", 3'd3, SMemLw);
    step("lw_w", 3'd4, SWbLw);
    chk("lw_ret", instr_retired, 32'd2);

    // BEQ taken, BEQ not taken, BNE taken
    opcode = 6'b000100; zero = 1'b1;
    step("beq1_f", 3'd0, SFetch);
    step("beq1_d", 3'd1, SNone);
    step("beq1_e", 3'd2, SBrTaken);
    zero = 1'b0;
    step("beq0_f", 3'd0, SFetch);
    step("beq0_d", 3'd1, SNone);
    step("beq0_e", 3'd2, SBrNot);
    opcode = 6'b000101;
    step("bne_f", 3'd0, SFetch);
    step("bne_d", 3'd1, SNone);
    step("bne_e", 3'd2, SBrTaken);
    chk("br_ret", instr_retired, 32'd5);

    // JAL then JR
    opcode = 6'b000011;
    step("jal_f", 3'd0, SFetch);
    step("jal_d", 3'd1, SNone);
    step("jal_e", 3'd2, SJal);
    opcode = 6'b000000; funct = 6'b001000;
    step("jr_f", 3'd0, SFetch);
    step("jr_d", 3'd1, SNone);
    step("jr_e", 3'd2, SJr);
    chk("jmp_ret", instr_retired, 32'd7);

    // Illegal opcode: sticky FAULT, strobes dead, counter frozen
    opcode = 6'b111111;
    step("ill_f", 3'd0, SFetch);
    step("ill_d", 3'd1, SNone);
    for (int i = 0; i < 10; i++) begin
      chk("ill_fault", 32'(fault), 32'd1);
      step("ill_hold", 3'd7, SNone);
    end
    chk("ill_ret", instr_retired, 32'd7);
    reset = 1'b1;
    step("ill_rst", 3'd7, SNone);
    reset = 1'b0;
    chk("ill_rst_state", 32'(state), 32'd0);
    chk("ill_rst_fault", 32'(fault), 32'd0);
    chk("ill_rst_ret", instr_retired, 32'd0);

    // SW, zero wait
    opcode = 6'b101011;
    step("sw_f", 3'd0, SFetch);
    step("sw_d", 3'd1, SNone);
    step("sw_e", 3'd2, SNone);
    step("sw_m", 3'd3, SMemSwDone);
    chk("sw_ret", instr_retired, 32'd1);

    // SW aborted by reset in MEM
    step("swr_f", 3'd0, SFetch);
    step("swr_d", 3'd1, SNone);
    step("swr_e", 3'd2, SNone);
    mem_ready = 1'b0;
    step("swr_m", 3'd3, SMemSw);
    reset = 1'b1; mem_ready = 1'b1;
    step("swr_rst", 3'd3, SNone);
    reset = 1'b0; mem_ready = 1'b0;
    chk("swr_ret", instr_retired, 32'd0);

    // mem_ready on the last permitted wait cycle wins over the timeout
    for (int i = 0; i < 14; i++) step("win_wait", 3'd0, SWait);
    mem_ready = 1'b1;
    step("win_rdy", 3'd0, SFetch);
    chk("win_state", 32'(state), 32'd1);
    chk("win_fault", 32'(fault), 32'd0);

    // Fetch timeout: 15 wait cycles then FAULT
    reset = 1'b1;
    step("to_rst", 3'd1, SNone);
    reset = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("to_wait", 3'd0, SWait);
    chk("to_state", 32'(state), 32'd7);
    chk("to_fault", 32'(fault), 32'd1);
    step("to_hold", 3'd7, SNone);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
